// File: rtl/cardinal_pkg.sv
// Shared Cardinal NIC/router definitions: packet geometry, VC polarity, tx FSM encoding.
package cardinal_pkg;

  localparam int PKT_WIDTH = 64;
  localparam int VC_BIT    = 0;

  localparam logic POL_EVEN = 1'b0;
  localparam logic POL_ODD  = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // A held packet may only be injected when its VC bit matches the ring's current polarity.
  function automatic logic vc_matches(input logic vc, input logic polarity);
    return vc == polarity;
  endfunction

endpackage

// File: rtl/cardinal_stat_counter.sv
// Debug statistics counter: synchronous clear beats increment; wraps or saturates.
// Latency: count reflects inc/clr one cycle later; no backpressure.
module cardinal_stat_counter #(
  parameter int WIDTH    = 16,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] MAX = '1;

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      if (!(SATURATE && (count_q == MAX))) begin
        count_d = count_q + ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/cardinal_nic_net_tx.sv
// Cardinal NIC network transmit: pops the output buffer into a holding register and injects on the ring.
// Latency: pop in t, earliest send in t+1; backpressure: holds on net_ro=0 or VC/polarity mismatch, no pop meanwhile.
module cardinal_nic_net_tx #(
  parameter int PKT_WIDTH = cardinal_pkg::PKT_WIDTH,
  parameter int VC_BIT    = cardinal_pkg::VC_BIT,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 buf_status,
  input  logic [0:PKT_WIDTH-1] buf_data,
  output logic                 buf_read_en,
  input  logic                 net_ro,
  input  logic                 net_polarity,
  output logic                 net_so,
  output logic [0:PKT_WIDTH-1] net_do,
  input  logic                 stat_clr,
  output logic [CNT_WIDTH-1:0] sent_cnt,
  output logic [CNT_WIDTH-1:0] stall_cnt
);

  import cardinal_pkg::*;

  state_t               state_q;
  state_t               state_d;
  logic [0:PKT_WIDTH-1] hold_q;
  logic [0:PKT_WIDTH-1] hold_d;

  logic eligible;
  logic send;
  logic stall;

  always_comb begin
    eligible = (state_q == HOLD) && vc_matches(hold_q[VC_BIT], net_polarity);
    send     = eligible && net_ro;
    stall    = (state_q == HOLD) && !send;
  end

  // Outputs are forced low while reset is asserted, even if the buffer still reports a packet.
  always_comb begin
    net_so      = send;
    net_do      = send ? hold_q : '0;
    buf_read_en = !reset && buf_status && ((state_q == IDLE) || send);
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (buf_status) begin
          hold_d  = buf_data;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (send) begin
          if (buf_status) begin
            hold_d = buf_data;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  cardinal_stat_counter #(
    .WIDTH    (CNT_WIDTH),
    .SATURATE (1'b0)
  ) u_sent_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (stat_clr),
    .inc   (send),
    .count (sent_cnt)
  );

  cardinal_stat_counter #(
    .WIDTH    (CNT_WIDTH),
    .SATURATE (1'b1)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (stat_clr),
    .inc   (stall),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_cardinal_nic_net_tx.sv
// Directed bench for cardinal_nic_net_tx with 4-bit counters so wrap and saturation are reachable.
module tb_cardinal_nic_net_tx;

  localparam int PW = 64;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          buf_status = 1'b0;
  logic [0:PW-1] buf_data = '0;
  logic          buf_read_en;
  logic          net_ro = 1'b0;
  logic          net_polarity = 1'b0;
  logic          net_so;
  logic [0:PW-1] net_do;
  logic          stat_clr = 1'b0;
  logic [CW-1:0] sent_cnt;
  logic [CW-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  cardinal_nic_net_tx #(
    .PKT_WIDTH (PW),
    .VC_BIT    (0),
    .CNT_WIDTH (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .buf_status   (buf_status),
    .buf_data     (buf_data),
    .buf_read_en  (buf_read_en),
    .net_ro       (net_ro),
    .net_polarity (net_polarity),
    .net_so       (net_so),
    .net_do       (net_do),
    .stat_clr     (stat_clr),
    .sent_cnt     (sent_cnt),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  // Bit 0 (the MSB) is the VC bit.
  function automatic logic [0:PW-1] mkpkt(input logic vc, input logic [31:0] tag);
    return {vc, 31'h0123_4567, tag};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    stat_clr   = 1'b1;
    buf_status = 1'b0;
    next_cycle();
    stat_clr = 1'b0;
  endtask

  task automatic test_reset();
    buf_status = 1'b1;
    buf_data   = mkpkt(1'b0, 32'hDEAD_BEEF);
    net_ro     = 1'b1;
    #2;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (buf_read_en !== 1'b0) begin errors++; $display("FAIL reset_read_en got=%b exp=0", buf_read_en); end
    checks++; if (net_so !== 1'b0) begin errors++; $display("FAIL reset_so got=%b exp=0", net_so); end
    checks++; if (net_do !== '0) begin errors++; $display("FAIL reset_do got=%h exp=0", net_do); end
    checks++; if (sent_cnt !== '0 || stall_cnt !== '0) begin errors++; $display("FAIL reset_cnt sent=%0d stall=%0d exp=0/0", sent_cnt, stall_cnt); end
    reset      = 1'b0;
    buf_status = 1'b0;
    next_cycle();
    checks++; if (net_so !== 1'b0) begin errors++; $display("FAIL reset_release_so got=%b exp=0", net_so); end
  endtask

  task automatic test_single();
    logic [0:PW-1] p;
    p = 64'h0123_4567_89AB_CDEE;
    buf_status   = 1'b1;
    buf_data     = p;
    net_polarity = 1'b0;
    net_ro       = 1'b1;
    #1;
    checks++; if (buf_read_en !== 1'b1) begin errors++; $display("FAIL single_pop got=%b exp=1", buf_read_en); end
    checks++; if (net_so !== 1'b0) begin errors++; $display("FAIL single_so_c0 got=%b exp=0", net_so); end
    next_cycle();
    buf_status = 1'b0;
    #1;
    checks++; if (net_so !== 1'b1) begin errors++; $display("FAIL single_so_c1 got=%b exp=1", net_so); end
    checks++; if (net_do !== p) begin errors++; $display("FAIL single_do got=%h exp=%h", net_do, p); end
    checks++; if (buf_read_en !== 1'b0) begin errors++; $display("FAIL single_no_pop got=%b exp=0", buf_read_en); end
    next_cycle();
    checks++; if (net_so !== 1'b0) begin errors++; $display("FAIL single_so_c2 got=%b exp=0", net_so); end
    checks++; if (sent_cnt !== 4'd1) begin errors++; $display("FAIL single_sent got=%0d exp=1", sent_cnt); end
    checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL single_stall got=%0d exp=0", stall_cnt); end
  endtask

  task automatic test_polarity_wait();
    logic [0:PW-1] p;
    p = 64'h0123_4567_89AB_CDEE;
    clear_stats();
    buf_status   = 1'b1;
    buf_data     = p;
    net_polarity = 1'b1;
    net_ro       = 1'b1;
    next_cycle();
    buf_data = mkpkt(1'b1, 32'h0000_0002);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (net_so !== 1'b0 || buf_read_en !== 1'b0) begin errors++; $display("FAIL polwait_hold%0d so=%b rd=%b exp=0/0", i, net_so, buf_read_en); end
      next_cycle();
    end
    buf_status   = 1'b0;
    net_polarity = 1'b0;
    #1;
    checks++; if (net_so !== 1'b1 || net_do !== p) begin errors++; $display("FAIL polwait_send so=%b do=%h exp=1/%h", net_so, net_do, p); end
    next_cycle();
    checks++; if (stall_cnt !== 4'd3) begin errors++; $display("FAIL polwait_stall got=%0d exp=3", stall_cnt); end
    checks++; if (sent_cnt !== 4'd1) begin errors++; $display("FAIL polwait_sent got=%0d exp=1", sent_cnt); end
  endtask

  task automatic test_backpressure();
    logic [0:PW-1] p;
    p = mkpkt(1'b1, 32'h0000_0003);
    clear_stats();
    buf_status   = 1'b1;
    buf_data     = p;
    net_polarity = 1'b1;
    net_ro       = 1'b0;
    next_cycle();
    buf_status = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (net_so !== 1'b0 || net_do !== '0) begin errors++; $display("FAIL bp_hold%0d so=%b do=%h exp=0/0", i, net_so, net_do); end
      next_cycle();
    end
    net_ro = 1'b1;
    #1;
    checks++; if (net_so !== 1'b1 || net_do !== p) begin errors++; $display("FAIL bp_send so=%b do=%h exp=1/%h", net_so, net_do, p); end
    next_cycle();
    checks++; if (stall_cnt !== 4'd5 || sent_cnt !== 4'd1) begin errors++; $display("FAIL bp_cnt stall=%0d sent=%0d exp=5/1", stall_cnt, sent_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [0:PW-1] pk [4];
    for (int i = 0; i < 4; i++) pk[i] = mkpkt(1'(i % 2), 32'hB000_0000 + 32'(i));
    clear_stats();
    buf_status   = 1'b1;
    buf_data     = pk[0];
    net_polarity = 1'b1;
    net_ro       = 1'b1;
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      net_polarity = 1'(i % 2);
      buf_status   = (i < 3);
      buf_data     = (i < 3) ? pk[i+1] : '0;
      #1;
      checks++; if (net_so !== 1'b1 || net_do !== pk[i]) begin errors++; $display("FAIL b2b_send%0d so=%b do=%h exp=1/%h", i, net_so, net_do, pk[i]); end
      checks++; if (buf_read_en !== (i < 3)) begin errors++; $display("FAIL b2b_pop%0d got=%b exp=%b", i, buf_read_en, (i < 3)); end
      next_cycle();
    end
    checks++; if (sent_cnt !== 4'd4 || stall_cnt !== 4'd0) begin errors++; $display("FAIL b2b_cnt sent=%0d stall=%0d exp=4/0", sent_cnt, stall_cnt); end
  endtask

  task automatic test_mid_hold_reset();
    logic [0:PW-1] p2;
    p2 = mkpkt(1'b0, 32'h0000_0055);
    clear_stats();
    buf_status   = 1'b1;
    buf_data     = mkpkt(1'b0, 32'h0000_0044);
    net_polarity = 1'b1;
    net_ro       = 1'b1;
    next_cycle();
    next_cycle();
    net_polarity = 1'b0;
    buf_data     = p2;
    #1;
    checks++; if (net_so !== 1'b1) begin errors++; $display("FAIL mhr_pre_so got=%b exp=1", net_so); end
    reset = 1'b1;
    #1;
    checks++; if (net_so !== 1'b0 || net_do !== '0 || buf_read_en !== 1'b0) begin errors++; $display("FAIL mhr_outputs so=%b do=%h rd=%b exp=0/0/0", net_so, net_do, buf_read_en); end
    checks++; if (sent_cnt !== '0 || stall_cnt !== '0) begin errors++; $display("FAIL mhr_cnt sent=%0d stall=%0d exp=0/0", sent_cnt, stall_cnt); end
    next_cycle();
    reset      = 1'b0;
    buf_status = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (net_so !== 1'b0) begin errors++; $display("FAIL mhr_idle%0d so=%b exp=0", i, net_so); end
      next_cycle();
    end
    buf_status = 1'b1;
    buf_data   = p2;
    next_cycle();
    buf_status = 1'b0;
    #1;
    checks++; if (net_so !== 1'b1 || net_do !== p2) begin errors++; $display("FAIL mhr_new so=%b do=%h exp=1/%h", net_so, net_do, p2); end
    next_cycle();
  endtask

  task automatic test_counter_edges();
    clear_stats();
    buf_status   = 1'b1;
    buf_data     = mkpkt(1'b0, 32'hC000_0000);
    net_polarity = 1'b1;
    net_ro       = 1'b1;
    next_cycle();
    buf_status = 1'b0;
    repeat (20) next_cycle();
    checks++; if (stall_cnt !== 4'd15) begin errors++; $display("FAIL cnt_stall_sat got=%0d exp=15", stall_cnt); end
    for (int i = 0; i < 17; i++) begin
      net_polarity = 1'(i % 2);
      buf_status   = (i < 16);
      buf_data     = mkpkt(1'((i + 1) % 2), 32'hC000_0000 + 32'(i + 1));
      #1;
      checks++; if (net_so !== 1'b1) begin errors++; $display("FAIL cnt_send%0d so=%b exp=1", i, net_so); end
      next_cycle();
    end
    checks++; if (sent_cnt !== 4'd1) begin errors++; $display("FAIL cnt_sent_wrap got=%0d exp=1", sent_cnt); end
    checks++; if (stall_cnt !== 4'd15) begin errors++; $display("FAIL cnt_stall_hold got=%0d exp=15", stall_cnt); end
    buf_status   = 1'b1;
    buf_data     = mkpkt(1'b0, 32'hC000_00FF);
    net_polarity = 1'b0;
    next_cycle();
    buf_status = 1'b0;
    stat_clr   = 1'b1;
    #1;
    checks++; if (net_so !== 1'b1) begin errors++; $display("FAIL cnt_clr_send so=%b exp=1", net_so); end
    next_cycle();
    stat_clr = 1'b0;
    checks++; if (sent_cnt !== '0 || stall_cnt !== '0) begin errors++; $display("FAIL cnt_clr sent=%0d stall=%0d exp=0/0", sent_cnt, stall_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_polarity_wait();
    test_backpressure();
    test_back_to_back();
    test_mid_hold_reset();
    test_counter_edges();
    $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cardinal_nic_net_tx.md
# cardinal_nic_net_tx

Network-side transmit stage of the Cardinal NIC. It sits directly downstream of the NIC output channel buffer (`cardinal_nic_buffer`, processor-to-network direction). It pops one 64-bit packet at a time from that buffer into a holding register. It injects the packet onto the ring router's local input port using the `so`/`ro` handshake, gated by the ring's even/odd virtual-channel polarity. It also keeps injection statistics for debug.

## Interface
Parameters:
- `PKT_WIDTH`, 64: packet width. Bit 0 is the MSB in `[0:PKT_WIDTH-1]` ordering.
- `VC_BIT`, 0: index of the virtual-channel bit within the packet.
- `CNT_WIDTH`, 16: width of the statistics counters.

Ports:
- `clk`, input, 1: the only clock; all state changes on its rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `buf_status`, input, 1: output buffer full flag (1 = packet valid).
- `buf_data`, input, `[0:PKT_WIDTH-1]`: output buffer data.
- `buf_read_en`, output, 1: pop strobe to the output buffer.
- `net_ro`, input, 1: router ready to accept from the NIC.
- `net_polarity`, input, 1: ring polarity; 0 = even, 1 = odd.
- `net_so`, output, 1: send strobe to the router.
- `net_do`, output, `[0:PKT_WIDTH-1]`: packet to the router.
- `stat_clr`, input, 1: synchronous clear of both counters.
- `sent_cnt`, output, `CNT_WIDTH`: packets injected; wraps.
- `stall_cnt`, output, `CNT_WIDTH`: cycles spent holding a packet without sending; saturates at all-ones.

## Operation
FSM with two states, `IDLE` and `HOLD`.

**Reset values.** Asynchronous reset forces:
- state = `IDLE`
- holding register = 0
- `sent_cnt` = 0, `stall_cnt` = 0
- `net_so` = 0, `net_do` = 0, `buf_read_en` = 0

**Combinational signals.**
- `eligible` = (state == `HOLD`) & (hold[`VC_BIT`] == `net_polarity`)
- `send` = `eligible` & `net_ro`
- `net_so` = `send`
- `net_do` = `send` ? hold : 0. The output is zero whenever no packet is being sent.
- `buf_read_en` = `buf_status` & ((state == `IDLE`) | `send`)

**State behaviour.**
- `IDLE`:
  - `buf_status`=1: capture `buf_data` into hold, go to `HOLD`.
  - Otherwise stay in `IDLE`.
- `HOLD`:
  - `send`=1 and `buf_status`=1: load the new `buf_data` into hold and stay in `HOLD` (back-to-back).
  - `send`=1 and `buf_status`=0: go to `IDLE`.
  - `send`=0: keep hold and stay in `HOLD`.

**Counters.**
- `sent_cnt` increments by 1 on each `send`, wrapping modulo 2^`CNT_WIDTH`.
- `stall_cnt` increments on each cycle with state == `HOLD` & !`send`, saturating at 2^`CNT_WIDTH`-1.
- `stat_clr` takes priority over increments; a clear coinciding with a `send` leaves 0.

**Packet field.** The VC bit is passed through unchanged; this block never modifies packet contents.

## Timing
- **Pop latency.** Buffer full in cycle t gives `buf_read_en`=1 in cycle t and the packet held from t+1. The earliest `net_so` is in cycle t+1.
- **Buffer interaction.** The buffer clears its full flag on the edge after `buf_read_en`. This block never asserts `buf_read_en` while `buf_status`=0.
- **Handshake.** A transfer occurs on the edge that ends a cycle with `net_so`=1. `net_so` is never asserted while `net_ro`=0.
- **Throughput.** At most one packet per cycle. Under alternating polarity, a stream on a single VC injects every other cycle.
- **Wrong polarity.** While the held VC bit ≠ `net_polarity`: the packet is held, `stall_cnt` counts, and no pop occurs.
- **Reset mid-operation.** A held packet is discarded. The buffer is not refilled by this block.
- **Boundaries.**
  - `net_ro` dropping in a matching-polarity cycle means stall, not loss.
  - `buf_status` rising in the same cycle as a `send` gives a seamless reload.

## Structure
- **Shared package `cardinal_pkg`:** `PKT_WIDTH`, `VC_BIT`, the `IDLE`/`HOLD` state encoding, and polarity constants `POL_EVEN`=0 and `POL_ODD`=1. Other NIC and router blocks reuse these.
- **One sub-module, `cardinal_stat_counter`:** parameters `WIDTH` and `SATURATE`; inputs `clk`, `reset`, `clr`, `inc`; output `count`. It is instantiated twice: wrapping for `sent_cnt`, saturating for `stall_cnt`.
- The FSM, holding register and handshake logic live in the top module.

## Test plan
1. **Single packet, matching polarity.** Reset; `buf_status`=1 with `buf_data`=0x0123_4567_89AB_CDEE (VC=0) for one cycle; `net_polarity`=0 next cycle; `net_ro`=1. Expect: `buf_read_en` in cycle 0, `net_so`=1 with `net_do`=that value in cycle 1, `sent_cnt`=1.
2. **Polarity wait.** Same packet but `net_polarity`=1 for 3 cycles, then 0. Expect: `net_so` only in the 0-polarity cycle, `stall_cnt`=3, no second pop.
3. **Router backpressure.** Polarity matches, `net_ro`=0 for 5 cycles. Expect: `net_so`=0 and `net_do`=0 throughout, packet retained, then sent on the first cycle with `net_ro`=1.
4. **Back-to-back.** Buffer refilled during the send cycle, polarity toggling every cycle, packets with alternating VC. Expect: one send per cycle, `buf_read_en` coincident with each `send`, `sent_cnt`=4 after 4 packets.
5. **Mid-hold reset.** Assert `reset` asynchronously while in `HOLD`. Expect: all outputs 0 immediately, state `IDLE`, no `net_so` after release until a new packet arrives.
6. **Counter edges.** With `CNT_WIDTH`=4, hold for 20 stall cycles, then 17 sends. Expect: `stall_cnt`=15 (saturated) and `sent_cnt`=1 (wrapped). Then `stat_clr` concurrent with a `send` gives both counters 0.
